cdb_writeback_controller: RTL and testbench

Sequences result writeback into the 7-entry, 16-bit FP register file of the Tomasulo core. Arbitrates functional-unit results onto the single Common Data Bus (CDB) round-robin and keeps the register result-status table (producer tag per register). Drives the register file's single write port only when the broadcast tag matches the register's current producer. Sits between the functional units/reservation stations and the FP register file.

---
 rtl/cdb_writeback_controller_pkg.sv | 30 +++
 rtl/cdb_writeback_controller_rr_arbiter.sv | 57 +++++
 rtl/cdb_writeback_controller.sv | 172 +++++++++++++++++
 tb/tb_cdb_writeback_controller.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_writeback_controller_pkg.sv
// Shared widths, sizes and helpers for the CDB writeback controller.
package cdb_writeback_controller_pkg;

    localparam int NUM_REQ    = 3;
    localparam int TAG_W      = 3;
    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 7;
    localparam int PTR_W      = $clog2(NUM_REQ);

    // Tag value meaning "no pending producer": register file holds the value.
    localparam logic [TAG_W-1:0] NO_TAG = 3'd0;

    // Extract requester idx's tag from the packed tag bus.
    function automatic logic [TAG_W-1:0] req_tag(
        input logic [NUM_REQ*TAG_W-1:0] tags,
        input logic [PTR_W-1:0]         idx
    );
        return tags[int'(idx)*TAG_W +: TAG_W];
    endfunction

    // Extract requester idx's result from the packed data bus.
    function automatic logic [DATA_W-1:0] req_data(
        input logic [NUM_REQ*DATA_W-1:0] data,
        input logic [PTR_W-1:0]          idx
    );
        return data[int'(idx)*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/cdb_writeback_controller_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester after the last
// granted one. Grant is combinational; the pointer moves only on transfer.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    localparam int PTR_W  = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               block,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] cand_s;
    logic             found_s;

    // Scan requesters starting just after the pointer, wrapping once around.
    always_comb begin
        grant     = '0;
        grant_idx = ptr_r;
        found_s   = 1'b0;
        cand_s    = ptr_r;
        if (block) begin
            grant   = '0;
            found_s = 1'b0;
        end else begin
            for (int off = 0; off < NUM_REQ; off++) begin
                if (cand_s == PTR_W'(NUM_REQ - 1)) begin
                    cand_s = '0;
                end else begin
                    cand_s = cand_s + PTR_W'(1);
                end
                if (!found_s && valid[cand_s]) begin
                    found_s        = 1'b1;
                    grant[cand_s]  = 1'b1;
                    grant_idx      = cand_s;
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    // Remember the last granted index; a grant always means a transfer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r <= PTR_W'(NUM_REQ - 1);
        end else if (found_s) begin
            ptr_r <= grant_idx;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/cdb_writeback_controller.sv
// CDB writeback controller: arbitrates FU results onto the CDB, tracks the
// producer tag of each FP register and writes the register file on a match.
module cdb_writeback_controller
    import cdb_writeback_controller_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        reqValid,
    input  logic [NUM_REQ*TAG_W-1:0]  reqTag,
    input  logic [NUM_REQ*DATA_W-1:0] reqData,
    output logic [NUM_REQ-1:0]        reqReady,
    input  logic                      issueValid,
    input  logic [REG_ADDR_W-1:0]     issueDest,
    input  logic [TAG_W-1:0]          issueTag,
    input  logic                      flush,
    input  logic [REG_ADDR_W-1:0]     qAddrA,
    input  logic [REG_ADDR_W-1:0]     qAddrB,
    output logic [TAG_W-1:0]          qTagA,
    output logic [TAG_W-1:0]          qTagB,
    output logic                      cdbValid,
    output logic [TAG_W-1:0]          cdbTag,
    output logic [DATA_W-1:0]         cdbData,
    output logic                      regWriteEnable,
    output logic [REG_ADDR_W-1:0]     regAddress,
    output logic [DATA_W-1:0]         regData,
    output logic                      tagMatchError
);

    logic [NUM_REQ-1:0]    grant_s;
    logic [PTR_W-1:0]      grant_idx_s;
    logic                  transfer_s;

    logic                  cdb_valid_r;
    logic [TAG_W-1:0]      cdb_tag_r;
    logic [DATA_W-1:0]     cdb_data_r;
    logic                  tag_match_error_r;

    // Entry 0 is never written so address 0 always reads as "no producer".
    logic [TAG_W-1:0]      status_r [0:NUM_REGS];

    logic [NUM_REGS:0]     match_s;
    logic [REG_ADDR_W-1:0] wr_idx_s;
    logic                  multi_s;
    logic                  err_set_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clock     (clock),
        .reset_n   (reset_n),
        .valid     (reqValid),
        .block     (flush),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    assign reqReady      = grant_s;
    assign transfer_s    = |(grant_s & reqValid);
    assign cdbValid      = cdb_valid_r;
    assign cdbTag        = cdb_tag_r;
    assign cdbData       = cdb_data_r;
    assign tagMatchError = tag_match_error_r;

    // CDB broadcast registers: load on transfer, otherwise drop valid and hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cdb_valid_r <= 1'b0;
            cdb_tag_r   <= NO_TAG;
            cdb_data_r  <= 16'd0;
        end else if (flush) begin
            cdb_valid_r <= 1'b0;
            cdb_tag_r   <= cdb_tag_r;
            cdb_data_r  <= cdb_data_r;
        end else if (transfer_s) begin
            cdb_valid_r <= 1'b1;
            cdb_tag_r   <= req_tag(reqTag, grant_idx_s);
            cdb_data_r  <= req_data(reqData, grant_idx_s);
        end else begin
            cdb_valid_r <= 1'b0;
            cdb_tag_r   <= cdb_tag_r;
            cdb_data_r  <= cdb_data_r;
        end
    end

    // Compare the broadcast tag with every register's producer; pick the lowest hit.
    always_comb begin
        match_s  = 8'd0;
        wr_idx_s = 3'd0;
        for (int r = 1; r <= NUM_REGS; r++) begin
            if (cdb_valid_r && (cdb_tag_r != NO_TAG) && (status_r[r] == cdb_tag_r)) begin
                match_s[r] = 1'b1;
            end else begin
                match_s[r] = 1'b0;
            end
        end
        for (int r = NUM_REGS; r >= 1; r--) begin
            if (match_s[r]) begin
                wr_idx_s = REG_ADDR_W'(r);
            end else begin
                wr_idx_s = wr_idx_s;
            end
        end
    end

    // More than one hit leaves a bit set after clearing the lowest one.
    assign multi_s   = |(match_s & (match_s - 8'd1));
    assign err_set_s = cdb_valid_r && !flush && ((cdb_tag_r == NO_TAG) || multi_s);

    // Register-file write port, suppressed while flushing.
    always_comb begin
        regWriteEnable = 1'b0;
        regAddress     = 3'd0;
        regData        = 16'd0;
        if (!flush && (|match_s)) begin
            regWriteEnable = 1'b1;
            regAddress     = wr_idx_s;
            regData        = cdb_data_r;
        end else begin
            regWriteEnable = 1'b0;
        end
    end

    // Result-status table: flush clears all, issue beats a same-cycle clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r <= NUM_REGS; r++) begin
                status_r[r] <= NO_TAG;
            end
        end else if (flush) begin
            for (int r = 0; r <= NUM_REGS; r++) begin
                status_r[r] <= NO_TAG;
            end
        end else begin
            status_r[0] <= NO_TAG;
            for (int r = 1; r <= NUM_REGS; r++) begin
                if (issueValid && (issueDest == REG_ADDR_W'(r))) begin
                    status_r[r] <= issueTag;
                end else if (match_s[r]) begin
                    status_r[r] <= NO_TAG;
                end else begin
                    status_r[r] <= status_r[r];
                end
            end
        end
    end

    // Sticky flag for a zero broadcast tag or an ambiguous multi-register match.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_match_error_r <= 1'b0;
        end else if (err_set_s) begin
            tag_match_error_r <= 1'b1;
        end else begin
            tag_match_error_r <= tag_match_error_r;
        end
    end

    // Status read ports: current table contents, address 0 reads as no producer.
    always_comb begin
        qTagA = NO_TAG;
        qTagB = NO_TAG;
        if (qAddrA != 3'd0) begin
            qTagA = status_r[qAddrA];
        end else begin
            qTagA = NO_TAG;
        end
        if (qAddrB != 3'd0) begin
            qTagB = status_r[qAddrB];
        end else begin
            qTagB = NO_TAG;
        end
    end

endmodule

// File: tb/tb_cdb_writeback_controller.sv
// Directed bench for cdb_writeback_controller with a write-port scoreboard.
module tb_cdb_writeback_controller;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  reqValid;
    logic [8:0]  reqTag;
    logic [47:0] reqData;
    logic [2:0]  reqReady;
    logic        issueValid;
    logic [2:0]  issueDest;
    logic [2:0]  issueTag;
    logic        flush;
    logic [2:0]  qAddrA;
    logic [2:0]  qAddrB;
    logic [2:0]  qTagA;
    logic [2:0]  qTagB;
    logic        cdbValid;
    logic [2:0]  cdbTag;
    logic [15:0] cdbData;
    logic        regWriteEnable;
    logic [2:0]  regAddress;
    logic [15:0] regData;
    logic        tagMatchError;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    logic [2:0] exp_gnt [6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    logic [2:0] exp_tg  [6] = '{3'd7, 3'd5, 3'd6, 3'd7, 3'd5, 3'd6};

    cdb_writeback_controller dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .reqValid       (reqValid),
        .reqTag         (reqTag),
        .reqData        (reqData),
        .reqReady       (reqReady),
        .issueValid     (issueValid),
        .issueDest      (issueDest),
        .issueTag       (issueTag),
        .flush          (flush),
        .qAddrA         (qAddrA),
        .qAddrB         (qAddrB),
        .qTagA          (qTagA),
        .qTagB          (qTagB),
        .cdbValid       (cdbValid),
        .cdbTag         (cdbTag),
        .cdbData        (cdbData),
        .regWriteEnable (regWriteEnable),
        .regAddress     (regAddress),
        .regData        (regData),
        .tagMatchError  (tagMatchError)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Pops one expected write whenever the DUT drives the write port.
    task automatic sb_monitor();
        wr_t e;
        if (regWriteEnable === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_write", 32'(regWriteEnable), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_addr", 32'(regAddress), 32'(e.addr));
                chk("sb_data", 32'(regData), 32'(e.data));
            end
        end
    endtask

    task automatic settle();
        #2;
        sb_monitor();
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int idx, input logic v, input logic [2:0] t, input logic [15:0] d);
        reqValid[idx]        = v;
        reqTag[idx*3 +: 3]   = t;
        reqData[idx*16 +: 16] = d;
    endtask

    task automatic push_exp(input logic [2:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        reset_n    = 1'b0;
        reqValid   = 3'd0;
        reqTag     = 9'd0;
        reqData    = 48'd0;
        issueValid = 1'b0;
        issueDest  = 3'd0;
        issueTag   = 3'd0;
        flush      = 1'b0;
        qAddrA     = 3'd0;
        qAddrB     = 3'd0;

        // Reset state
        #2;
        chk("rst_cdbValid", 32'(cdbValid), 32'd0);
        chk("rst_cdbTag", 32'(cdbTag), 32'd0);
        chk("rst_cdbData", 32'(cdbData), 32'd0);
        chk("rst_regWriteEnable", 32'(regWriteEnable), 32'd0);
        chk("rst_regAddress", 32'(regAddress), 32'd0);
        chk("rst_regData", 32'(regData), 32'd0);
        chk("rst_tagMatchError", 32'(tagMatchError), 32'd0);
        chk("rst_qTagA", 32'(qTagA), 32'd0);
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        settle();
        chk("idle_reqReady", 32'(reqReady), 32'd0);
        next_cycle();

        // Basic writeback: R3 <- tag 2, requester 1 returns tag 2
        issueValid = 1'b1; issueDest = 3'd3; issueTag = 3'd2;
        settle();
        next_cycle();
        issueValid = 1'b0;
        qAddrA = 3'd3;
        set_req(1, 1'b1, 3'd2, 16'h00AB);
        push_exp(3'd3, 16'h00AB);
        settle();
        chk("t1_qTag_busy", 32'(qTagA), 32'd2);
        chk("t1_ready", 32'(reqReady), 32'b010);
        next_cycle();
        set_req(1, 1'b0, 3'd0, 16'h0000);
        settle();
        chk("t1_cdbValid", 32'(cdbValid), 32'd1);
        chk("t1_cdbTag", 32'(cdbTag), 32'd2);
        chk("t1_qTag_nobypass", 32'(qTagA), 32'd2);
        next_cycle();
        settle();
        chk("t1_qTag_cleared", 32'(qTagA), 32'd0);
        chk("t1_cdbValid_drop", 32'(cdbValid), 32'd0);
        chk("t1_no_write", 32'(regWriteEnable), 32'd0);

        // All three requesters valid continuously; tags match no register
        set_req(0, 1'b1, 3'd5, 16'h1111);
        set_req(1, 1'b1, 3'd6, 16'h2222);
        set_req(2, 1'b1, 3'd7, 16'h3333);
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("rr_grant", 32'(reqReady), 32'(exp_gnt[i]));
            if (i > 0) begin
                chk("rr_cdbTag", 32'(cdbTag), 32'(exp_tg[i-1]));
                chk("rr_no_write", 32'(regWriteEnable), 32'd0);
            end
            next_cycle();
        end
        flush = 1'b1;
        settle();
        chk("flush_no_grant", 32'(reqReady), 32'd0);
        chk("nomatch_cdbValid", 32'(cdbValid), 32'd1);
        chk("nomatch_cdbTag", 32'(cdbTag), 32'd6);
        chk("nomatch_no_error", 32'(tagMatchError), 32'd0);
        next_cycle();
        flush = 1'b0;
        settle();
        chk("flush_cdb_dropped", 32'(cdbValid), 32'd0);
        chk("rr_ptr_held", 32'(reqReady), 32'b100);
        next_cycle();
        reqValid = 3'd0;
        settle();
        chk("rr_last_cdbTag", 32'(cdbTag), 32'd7);

        next_cycle();

        // Same-cycle issue and match on R5: RF written, issue tag wins
        issueValid = 1'b1; issueDest = 3'd5; issueTag = 3'd1;
        settle();
        next_cycle();
        issueValid = 1'b0;
        set_req(0, 1'b1, 3'd1, 16'h5555);
        push_exp(3'd5, 16'h5555);
        settle();
        chk("t3_ready", 32'(reqReady), 32'b001);
        next_cycle();
        set_req(0, 1'b0, 3'd0, 16'h0000);
        issueValid = 1'b1; issueDest = 3'd5; issueTag = 3'd4;
        qAddrB = 3'd5;
        settle();
        chk("t3_cdbTag", 32'(cdbTag), 32'd1);
        chk("t3_qTag_before", 32'(qTagB), 32'd1);
        next_cycle();
        issueValid = 1'b0;
        settle();
        chk("t3_issue_wins", 32'(qTagB), 32'd4);

        // Two registers waiting on tag 3: write lowest, clear both, flag error
        issueValid = 1'b1; issueDest = 3'd2; issueTag = 3'd3;
        next_cycle();
        issueDest = 3'd4;
        next_cycle();
        issueValid = 1'b0;
        set_req(2, 1'b1, 3'd3, 16'h3333);
        push_exp(3'd2, 16'h3333);
        settle();
        chk("t5_ready", 32'(reqReady), 32'b100);
        next_cycle();
        set_req(2, 1'b0, 3'd0, 16'h0000);
        qAddrA = 3'd2; qAddrB = 3'd4;
        settle();
        chk("t5_R2_busy", 32'(qTagA), 32'd3);
        chk("t5_R4_busy", 32'(qTagB), 32'd3);
        chk("t5_err_not_yet", 32'(tagMatchError), 32'd0);
        next_cycle();
        settle();
        chk("t5_err_set", 32'(tagMatchError), 32'd1);
        chk("t5_R2_cleared", 32'(qTagA), 32'd0);
        chk("t5_R4_cleared", 32'(qTagB), 32'd0);

        // Flush with all registers busy and a broadcast in flight
        for (int r = 1; r <= 7; r++) begin
            issueValid = 1'b1; issueDest = 3'(r); issueTag = 3'(r);
            next_cycle();
        end
        issueValid = 1'b0;
        set_req(0, 1'b1, 3'd3, 16'hCCCC);
        settle();
        chk("t6_ready", 32'(reqReady), 32'b001);
        next_cycle();
        flush = 1'b1;
        set_req(0, 1'b1, 3'd2, 16'hDDDD);
        settle();
        chk("t6_flush_cdbValid", 32'(cdbValid), 32'd1);
        chk("t6_flush_no_write", 32'(regWriteEnable), 32'd0);
        chk("t6_flush_no_grant", 32'(reqReady), 32'd0);
        next_cycle();
        flush = 1'b0;
        settle();
        chk("t6_cdb_dropped", 32'(cdbValid), 32'd0);
        chk("t6_regrant", 32'(reqReady), 32'b001);
        set_req(0, 1'b0, 3'd0, 16'h0000);
        for (int r = 1; r <= 7; r++) begin
            qAddrA = 3'(r);
            #1;
            chk("t6_status_clear", 32'(qTagA), 32'd0);
        end
        next_cycle();

        // Asynchronous reset while a matching broadcast is on the CDB
        issueValid = 1'b1; issueDest = 3'd6; issueTag = 3'd5;
        next_cycle();
        issueValid = 1'b0;
        qAddrA = 3'd6;
        set_req(1, 1'b1, 3'd5, 16'h6666);
        settle();
        chk("t7_ready", 32'(reqReady), 32'b010);
        next_cycle();
        #2;
        chk("t7_cdbValid", 32'(cdbValid), 32'd1);
        chk("t7_pending_write", 32'(regWriteEnable), 32'd1);
        chk("t7_pending_addr", 32'(regAddress), 32'd6);
        reset_n = 1'b0;
        #1;
        chk("t7_rst_cdbValid", 32'(cdbValid), 32'd0);
        chk("t7_rst_cdbTag", 32'(cdbTag), 32'd0);
        chk("t7_rst_cdbData", 32'(cdbData), 32'd0);
        chk("t7_rst_regWriteEnable", 32'(regWriteEnable), 32'd0);
        chk("t7_rst_regAddress", 32'(regAddress), 32'd0);
        chk("t7_rst_regData", 32'(regData), 32'd0);
        chk("t7_rst_tagMatchError", 32'(tagMatchError), 32'd0);
        chk("t7_rst_qTag", 32'(qTagA), 32'd0);
        next_cycle();
        reset_n = 1'b1;
        settle();
        chk("t7_rearb", 32'(reqReady), 32'b010);
        next_cycle();
        set_req(1, 1'b0, 3'd0, 16'h0000);
        settle();
        chk("t7_rebroadcast", 32'(cdbValid), 32'd1);
        chk("t7_rebroadcast_tag", 32'(cdbTag), 32'd5);
        chk("t7_no_write_after_reset", 32'(regWriteEnable), 32'd0);
        next_cycle();

        // Broadcast of tag 0: never writes, sets the error flag
        set_req(0, 1'b1, 3'd0, 16'h0F0F);
        settle();
        chk("t8_ready", 32'(reqReady), 32'b001);
        next_cycle();
        set_req(0, 1'b0, 3'd0, 16'h0000);
        settle();
        chk("t8_cdbValid", 32'(cdbValid), 32'd1);
        chk("t8_no_write", 32'(regWriteEnable), 32'd0);
        chk("t8_err_not_yet", 32'(tagMatchError), 32'd0);
        next_cycle();
        settle();
        chk("t8_err_set", 32'(tagMatchError), 32'd1);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
